cflog_flush_ctrl: RTL
=====================

// Module: cflog_flush_ctrl
//
// PURPOSE
//  Sequencer for the control-flow log memory: accepts control-flow events, drives the
//  log write port (pointer/src/dest/wen) and detects full. Streams the whole log out
//  through a byte-wide TX handshake on full or on request, then rewinds the pointer.
//  Sits between the CPU branch monitor, the log memory and the UART transmitter;
//  stalls the CPU while the log cannot accept events.
//
// PARAMETERS
//  ADDR_MSB   6      MSB of log-memory word address (read_addr_hw width = ADDR_MSB+1)
//  LOG_WORDS  128    log capacity in 16-bit words; must be even, <= 2**(ADDR_MSB+1)
//  HDR_BYTE   8'hA5  first byte of every flush frame
//
// PORTS
//  mclk               in   1   clock
//  reset_n            in   1   asynchronous reset, active low
//  ev_valid           in   1   control-flow event present
//  ev_src             in   16  jump source address
//  ev_dest            in   16  jump destination address
//  ev_ready           out  1   event accepted when ev_valid & ev_ready
//  flush_req          in   1   single-cycle pulse: flush log now
//  cpu_hold           out  1   stall CPU (log full or flush in progress)
//  cflow_logs_ptr_din out  16  pointer to next empty log word (post-increment value)
//  cflow_src          out  16  word written at ptr-2
//  cflow_dest         out  16  word written at ptr-1
//  cflow_hw_wen       out  1   log write enable, one cycle per event
//  read_addr_hw       out  ADDR_MSB+1  log read address (combinational read)
//  read_val_log       in   16  log word at read_addr_hw, same cycle
//  tx_data            out  8   byte to transmitter
//  tx_valid           out  1   tx_data valid
//  tx_ready           in   1   transmitter accepts; byte transfers on tx_valid & tx_ready
//  flush_busy         out  1   high from leaving IDLE until return to IDLE
//  flush_done         out  1   one-cycle pulse at end of flush
//
// BEHAVIOUR
//  - Reset: all outputs 0, ptr=0, state IDLE, no pending write/flush. Reset mid-flush
//    aborts the frame; log contents are stale and unreferenced (ptr=0).
//  - ev_ready = (state==IDLE) & (ptr<LOG_WORDS) & ~flush_pend (combinational).
//  - Accept at edge N: ptr<=ptr+2 (16-bit); cflow_src/dest<=ev_src/dest; cflow_logs_ptr_din
//    <=ptr+2; cflow_hw_wen=1 during cycle N+1 only; memory written at edge N+2.
//    Back-to-back accepts allowed: wen stays high, one event per cycle.
//  - cpu_hold = (state!=IDLE) | (ptr==LOG_WORDS) | flush_pend.
//  - flush_pend set by flush_req in IDLE, or when ptr reaches LOG_WORDS. Flush starts
//    (IDLE->HDR) only when flush_pend & ~cflow_hw_wen, so last event is in memory.
//  - flush_req same cycle as accepted event: event logged first, flush includes it.
//  - flush_req while not IDLE: ignored (no re-queue).
//  - States: IDLE -> HDR -> CNT_LO -> CNT_HI -> (ptr==0 ? DONE : WORD_LO) ;
//    WORD_LO -> WORD_HI -> (idx==ptr-1 ? DONE : WORD_LO, idx++) ; DONE -> IDLE.
//    HDR sends HDR_BYTE; CNT_LO/HI send ptr[7:0], ptr[15:8] (word count);
//    WORD_LO/HI send read_val_log[7:0], [15:8] of word idx (idx from 0).
//  - On entering WORD_LO, read_addr_hw=idx; word latched into a 16-bit hold register;
//    read_addr_hw otherwise 0. Each state advances only on tx_valid & tx_ready; tx_data
//    stable while tx_valid & ~tx_ready. tx_valid low in IDLE/DONE.
//  - DONE: flush_done=1 one cycle, ptr<=0, cflow_logs_ptr_din<=0, flush_pend<=0.
//  - Empty flush (ptr==0): frame = A5 00 00, then done.
//  - Full: LOG_WORDS words in frame; ptr never exceeds LOG_WORDS, so memory guard never trips.
//
// STRUCTURE
//  - Shared include cflog_defines.v: state encodings, HDR_BYTE default, frame layout.
//  - Sub-module cflog_tx_serializer: 16-bit word in (valid/ready) -> two bytes out,
//    low first, with tx_valid/tx_ready handshake; used for count and log words.
//  - Top holds ptr, idx, flush_pend, FSM and write-port registers.
//
// TESTING
//  - 3 events (src 0x1000/0x2000 ..), flush_req, tx_ready=1 -> wen 3 cycles, ptr 6;
//    frame A5 06 00 then 6 words LSB-first matching src/dest order; flush_done; ptr 0.
//  - LOG_WORDS=8: 5 back-to-back events -> 4 accepted, ev_ready/cpu_hold high at ptr 8,
//    auto flush of 8 words, 5th event accepted after flush_done.
//  - flush_req with empty log -> exactly A5 00 00, flush_done 1 cycle, no read of memory.
//  - tx_ready random stalls (0-5 cycles) -> tx_data stable while stalled, no lost/dup bytes.
//  - flush_req same cycle as event -> event included, count includes it; second
//    flush_req mid-frame ignored (single frame).
//  - reset_n low mid-WORD_HI -> all outputs 0 immediately; new event after reset writes ptr 2.

Source files
------------

// File: rtl/cflog_flush_ctrl_pkg.sv
// Shared types and constants for the control-flow log flush sequencer.
// Frame: HDR_BYTE, word count lo/hi, then every log word low byte first.
package cflog_flush_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_CNT_LO,
        ST_CNT_HI,
        ST_WORD_LO,
        ST_WORD_HI,
        ST_DONE
    } fl_state_e;

    localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;
    localparam int         PTR_W        = 16;
    localparam int         WORDS_PER_EV = 2;

    function automatic logic [PTR_W-1:0] ptr_step(input logic [PTR_W-1:0] p);
        return p + PTR_W'(WORDS_PER_EV);
    endfunction

endpackage

// File: rtl/cflog_tx_serializer.sv
// Splits a 16-bit word into two bytes, low byte first, over a
// valid/ready byte handshake. Accepts a new word only when idle.
module cflog_tx_serializer (
    input  logic        mclk,
    input  logic        reset_n,
    input  logic        w_valid,
    input  logic [15:0] w_data,
    output logic        w_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    logic [15:0] hold;
    logic        busy;
    logic        hi;

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            hold <= '0;
            busy <= 1'b0;
            hi   <= 1'b0;
        end else if (busy) begin
            if (tx_ready) begin
                if (hi) begin
                    busy <= 1'b0;
                    hi   <= 1'b0;
                end else begin
                    hi <= 1'b1;
                end
            end
        end else if (w_valid) begin
            hold <= w_data;
            busy <= 1'b1;
            hi   <= 1'b0;
        end
    end

    assign w_ready  = ~busy;
    assign tx_valid = busy;
    assign tx_data  = !busy ? 8'h00 : (hi ? hold[15:8] : hold[7:0]);

endmodule

// File: rtl/cflog_flush_ctrl.sv
// Control-flow log sequencer: logs jump events, detects full and
// streams the whole log to the byte transmitter before rewinding.
module cflog_flush_ctrl
    import cflog_flush_ctrl_pkg::*;
#(
    parameter int         ADDR_MSB  = 6,
    parameter int         LOG_WORDS = 128,
    parameter logic [7:0] HDR_BYTE  = HDR_BYTE_DEF
) (
    input  logic              mclk,
    input  logic              reset_n,
    input  logic              ev_valid,
    input  logic [15:0]       ev_src,
    input  logic [15:0]       ev_dest,
    output logic              ev_ready,
    input  logic              flush_req,
    output logic              cpu_hold,
    output logic [15:0]       cflow_logs_ptr_din,
    output logic [15:0]       cflow_src,
    output logic [15:0]       cflow_dest,
    output logic              cflow_hw_wen,
    output logic [ADDR_MSB:0] read_addr_hw,
    input  logic [15:0]       read_val_log,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              flush_busy,
    output logic              flush_done
);

    localparam logic [15:0] LOG_LIM = 16'(LOG_WORDS);

    fl_state_e   state;
    logic [15:0] ptr;
    logic [15:0] idx;
    logic [15:0] idx_inc;
    logic        flush_pend;
    logic        armed;
    logic        is_idle;
    logic        ev_acc;
    logic        tx_fire;
    logic        ser_ld;
    logic        ser_ready;
    logic        ser_valid;
    logic [15:0] ser_word;
    logic [7:0]  ser_data;

    assign is_idle  = (state == ST_IDLE);
    // armed keeps ev_ready low while reset is held
    assign ev_ready = armed & is_idle & (ptr < LOG_LIM) & ~flush_pend;
    assign ev_acc   = ev_valid & ev_ready;
    assign cpu_hold = ~is_idle | (ptr == LOG_LIM) | flush_pend;

    assign flush_busy = ~is_idle;
    assign tx_valid   = (state == ST_HDR) | ser_valid;
    assign tx_data    = (state == ST_HDR) ? HDR_BYTE : ser_data;
    assign tx_fire    = tx_valid & tx_ready;

    assign ser_ld   = ser_ready &
                      ((state == ST_CNT_LO) | (state == ST_WORD_LO));
    assign ser_word = (state == ST_CNT_LO) ? ptr : read_val_log;
    assign idx_inc  = idx + 16'd1;

    cflog_tx_serializer u_ser (
        .mclk     (mclk),
        .reset_n  (reset_n),
        .w_valid  (ser_ld),
        .w_data   (ser_word),
        .w_ready  (ser_ready),
        .tx_data  (ser_data),
        .tx_valid (ser_valid),
        .tx_ready (tx_ready)
    );

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= ST_IDLE;
            ptr                <= '0;
            idx                <= '0;
            flush_pend         <= 1'b0;
            armed              <= 1'b0;
            cflow_logs_ptr_din <= '0;
            cflow_src          <= '0;
            cflow_dest         <= '0;
            cflow_hw_wen       <= 1'b0;
            read_addr_hw       <= '0;
            flush_done         <= 1'b0;
        end else begin
            armed        <= 1'b1;
            cflow_hw_wen <= ev_acc;
            flush_done   <= 1'b0;
            if (ev_acc) begin
                ptr                <= ptr_step(ptr);
                cflow_logs_ptr_din <= ptr_step(ptr);
                cflow_src          <= ev_src;
                cflow_dest         <= ev_dest;
            end
            unique case (state)
                ST_IDLE: begin
                    if (flush_req | (ptr == LOG_LIM))
                        flush_pend <= 1'b1;
                    // wait out the last write so memory holds every event
                    if (flush_pend & ~cflow_hw_wen)
                        state <= ST_HDR;
                end
                ST_HDR: begin
                    if (tx_fire)
                        state <= ST_CNT_LO;
                end
                ST_CNT_LO: begin
                    if (tx_fire)
                        state <= ST_CNT_HI;
                end
                ST_CNT_HI: begin
                    if (tx_fire) begin
                        idx          <= '0;
                        read_addr_hw <= '0;
                        if (ptr == 16'd0) begin
                            state      <= ST_DONE;
                            flush_done <= 1'b1;
                        end else begin
                            state <= ST_WORD_LO;
                        end
                    end
                end
                ST_WORD_LO: begin
                    if (ser_ld)
                        read_addr_hw <= '0;
                    if (tx_fire)
                        state <= ST_WORD_HI;
                end
                ST_WORD_HI: begin
                    if (tx_fire) begin
                        if (idx == ptr - 16'd1) begin
                            state      <= ST_DONE;
                            flush_done <= 1'b1;
                        end else begin
                            idx          <= idx_inc;
                            read_addr_hw <= idx_inc[ADDR_MSB:0];
                            state        <= ST_WORD_LO;
                        end
                    end
                end
                ST_DONE: begin
                    ptr                <= '0;
                    cflow_logs_ptr_din <= '0;
                    flush_pend         <= 1'b0;
                    state              <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
